led_code_blinker: RTL and testbench



---
 rtl/led_code_blinker.sv | 96 +++++++++
 tb/tb_led_code_blinker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/led_code_blinker.sv
// led_code_blinker: blinks a 4-bit status code on all LEDs, then holds a dark gap
// and either replays the code or returns to idle; on-phases are PWM dimmed.
module led_code_blinker #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned ON_MS    = 200,
    parameter int unsigned OFF_MS   = 200,
    parameter int unsigned GAP_MS   = 1000,
    parameter int unsigned LED_W    = 4,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                code_valid,
    output logic                code_ready,
    input  logic [3:0]          code,
    input  logic                repeat_en,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                busy,
    output logic [LED_W-1:0]    led
);
    localparam logic [31:0] ON_CYC  = 32'(CLK_FREQ / 1000 * ON_MS);
    localparam logic [31:0] OFF_CYC = 32'(CLK_FREQ / 1000 * OFF_MS);
    localparam logic [31:0] GAP_CYC = 32'(CLK_FREQ / 1000 * GAP_MS);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [3:0]          code_q, code_d;
    logic [3:0]          blinks_q, blinks_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [LED_W-1:0]    led_q, led_d;
    logic                hs;
    logic                last;
    logic                pwm_on;

    assign code_ready = state_q == IDLE || state_q == GAP;
    assign busy       = state_q != IDLE;
    assign led        = led_q;
    assign hs         = code_valid && code_ready;
    assign pwm_on     = (&brightness) || (pwm_q < brightness);

    always_comb
        last = cnt_q == (state_q == ON ? ON_CYC : state_q == OFF ? OFF_CYC : GAP_CYC) - 32'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        code_d   = code_q;
        blinks_d = blinks_q;
        case (state_q)
            IDLE: cnt_d = '0;
            ON: if (last) begin
                cnt_d   = '0;
                state_d = blinks_q < code_q ? OFF : GAP;
            end
            OFF: if (last) begin
                cnt_d    = '0;
                state_d  = ON;
                blinks_d = blinks_q + 4'd1;
            end
            GAP: if (last) begin
                cnt_d    = '0;
                blinks_d = 4'd1;
                state_d  = !repeat_en ? IDLE : code_q == 4'd0 ? GAP : ON;
            end
            default: state_d = IDLE;
        endcase
        // a new code wins over gap expiry on the same cycle
        if (hs) begin
            code_d   = code;
            cnt_d    = '0;
            blinks_d = 4'd1;
            state_d  = code == 4'd0 ? GAP : ON;
        end
        led_d = state_d == ON ? {LED_W{pwm_on}} : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            blinks_q <= '0;
            pwm_q    <= '0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            blinks_q <= blinks_d;
            pwm_q    <= pwm_q + 1'b1;
            led_q    <= led_d;
        end
    end
endmodule

// File: tb/tb_led_code_blinker.sv
// tb_led_code_blinker: directed and randomized checks of the code blinker against a
// timeline model computed from the blink/gap durations.
module tb_led_code_blinker;
    localparam int ON = 3, OFF = 2, GAP = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code = 4'd0;
    logic       repeat_en = 1'b0;
    logic [3:0] brightness = 4'hF;
    logic       ready1, busy1, ready2, busy2;
    logic [3:0] led1, led2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    led_code_blinker #(.CLK_FREQ(1000), .ON_MS(ON), .OFF_MS(OFF), .GAP_MS(GAP), .LED_W(4), .PWM_BITS(4)) dut1 (
        .clk(clk), .rstn(rstn), .code_valid(code_valid), .code_ready(ready1), .code(code),
        .repeat_en(repeat_en), .brightness(brightness), .busy(busy1), .led(led1));

    led_code_blinker #(.CLK_FREQ(1000), .ON_MS(32), .OFF_MS(OFF), .GAP_MS(GAP), .LED_W(4), .PWM_BITS(4)) dut2 (
        .clk(clk), .rstn(rstn), .code_valid(code_valid), .code_ready(ready2), .code(code),
        .repeat_en(repeat_en), .brightness(brightness), .busy(busy2), .led(led2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c);
        chk("ready_at_send", 32'(ready1), 32'd1);
        code_valid = 1'b1;
        code = c;
        step();
        code_valid = 1'b0;
    endtask

    // expected {ready, busy, on} for cycle k after a handshake of code c, no repeat
    function automatic logic [2:0] model(input int c, input int k);
        int t, tot;
        logic on;
        t = k - 1;
        tot = c * ON + (c > 0 ? (c - 1) * OFF : 0);
        on = t < tot && (t % (ON + OFF)) < ON;
        return {!(t < tot), t < tot + GAP, on};
    endfunction

    task automatic run_code(input int c, input logic [3:0] br);
        logic [2:0] e;
        int len;
        brightness = br;
        send(4'(c));
        len = c * ON + (c > 0 ? (c - 1) * OFF : 0) + GAP;
        for (int k = 1; k <= len + 1; k++) begin
            e = model(c, k);
            chk("led", 32'(led1), e[0] && br == 4'hF ? 32'hF : 32'h0);
            chk("busy", 32'(busy1), 32'(e[1]));
            chk("ready", 32'(ready1), 32'(e[2]));
            if (k <= len) step();
        end
    endtask

    initial begin
        int cnt;
        logic on;
        #12;
        chk("rst_led1", 32'(led1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_led2", 32'(led2), 32'd0);
        step();
        rstn = 1'b1;
        step();
        run_code(2, 4'hF);
        // repeat mode, dropping repeat_en at cycle 10
        repeat_en = 1'b1;
        send(4'd1);
        for (int k = 1; k <= 17; k++) begin
            if (k == 10) repeat_en = 1'b0;
            on = k <= 11 && ((k - 1) % 8) < 3;
            chk("rep_led", 32'(led1), on ? 32'hF : 32'h0);
            chk("rep_busy", 32'(busy1), 32'(k < 17));
            chk("rep_ready", 32'(ready1), 32'(!on));
            if (k < 17) step();
        end
        // new code offered during blinking, accepted at first gap cycle
        send(4'd3);
        for (int k = 1; k < 5; k++) step();
        code_valid = 1'b1;
        code = 4'd1;
        for (int k = 5; k <= 13; k++) begin
            chk("held_ready", 32'(ready1), 32'd0);
            step();
        end
        chk("gap_ready", 32'(ready1), 32'd1);
        step();
        code_valid = 1'b0;
        for (int k = 15; k <= 23; k++) begin
            chk("new_led", 32'(led1), k <= 17 ? 32'hF : 32'h0);
            chk("new_busy", 32'(busy1), 32'(k < 23));
            if (k < 23) step();
        end
        run_code(0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            run_code(int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1 ? 4'hF : 4'h0);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("idle_busy", 32'(busy1), 32'd0);
            end
        end
        // PWM duty on the long-ON instance
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        for (int b = 0; b < 2; b++) begin
            brightness = b == 0 ? 4'd4 : 4'd0;
            chk("pwm_ready", 32'(ready2), 32'd1);
            code_valid = 1'b1;
            code = 4'd1;
            step();
            code_valid = 1'b0;
            cnt = 0;
            for (int k = 1; k <= 32; k++) begin
                if (led2 == 4'hF) cnt++;
                else if (led2 != 4'h0) chk("pwm_uniform", 32'(led2), 32'h0);
                if (k == 32) chk("pwm_on_ready", 32'(ready2), 32'd0);
                step();
            end
            chk("pwm_count", 32'(cnt), b == 0 ? 32'd8 : 32'd0);
            chk("pwm_gap_ready", 32'(ready2), 32'd1);
            chk("pwm_gap_busy", 32'(busy2), 32'd1);
            chk("pwm_gap_led", 32'(led2), 32'd0);
            for (int k = 33; k < 38; k++) step();
            chk("pwm_idle", 32'(busy2), 32'd0);
        end
        // asynchronous reset in the middle of an ON phase
        brightness = 4'hF;
        send(4'd2);
        step();
        chk("mid_led", 32'(led1), 32'hF);
        #2 rstn = 1'b0;
        #1;
        chk("arst_led", 32'(led1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_ready", 32'(ready1), 32'd1);
        step();
        rstn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("post_led", 32'(led1), 32'd0);
            chk("post_busy", 32'(busy1), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
